// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the arbiter.
// The master side is the requesters; the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [3:0]        req_op0;
  logic [3:0]        req_op1;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b0;
  logic [DATA_W-1:0] req_b1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        rsp_status;
  logic              rsp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_status, rsp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_status, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute stage (req 0)
// and the branch/compare unit (req 1); one atomic op at a time, registered response.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_status,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]        rsp_status_q, rsp_status_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              any_valid;
  logic              win;
  logic [3:0]        win_op;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;

  // With both valid the requester that was not served last wins; otherwise the lone one.
  always_comb begin
    any_valid = |bus.req_valid;
    win       = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    win_op    = win ? bus.req_op1 : bus.req_op0;
    win_a     = win ? bus.req_a1  : bus.req_a0;
    win_b     = win ? bus.req_b1  : bus.req_b0;
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_d         = gnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    rsp_err_d     = rsp_err_q;
    op_count_d    = op_count_q;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          bus.req_ready = win ? 2'b10 : 2'b01;
          gnt_d         = win;
          last_grant_d  = win;
          if (win_op <= 4'd3) begin
            op_d    = win_op;
            a_d     = win_a;
            b_d     = win_b;
            state_d = StExec;
          end else begin
            // Rejected op never reaches the ALU, so its input regs keep the last issued op.
            rsp_data_d   = '0;
            rsp_status_d = 3'b000;
            rsp_err_d    = 1'b1;
            state_d      = StResp;
          end
        end
      end
      StExec: begin
        rsp_data_d   = alu_out;
        rsp_status_d = alu_status;
        rsp_err_d    = 1'b0;
        state_d      = StResp;
      end
      StResp: begin
        bus.rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (bus.rsp_ready[gnt_q]) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_ain        = a_q;
  assign alu_bin        = b_q;
  assign alu_op         = op_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state_q != StIdle);
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural model of the shared ALU.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] alu_ain;
  logic [31:0] alu_bin;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic [2:0]  alu_status;
  logic        busy;
  logic [15:0] op_count;

  int          checks;
  int          errors;
  logic [15:0] exp_count;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_ain    (alu_ain),
    .alu_bin    (alu_bin),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_status (alu_status),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: status = {NEGATIVE, OVERFLOW, ZERO}
  logic m_ovf;
  always_comb begin
    alu_out = '0;
    m_ovf   = 1'b0;
    case (alu_op)
      4'd0: begin
        alu_out = alu_ain + alu_bin;
        m_ovf   = (alu_ain[31] == alu_bin[31]) && (alu_out[31] != alu_ain[31]);
      end
      4'd1: begin
        alu_out = alu_ain - alu_bin;
        m_ovf   = (alu_ain[31] != alu_bin[31]) && (alu_out[31] != alu_ain[31]);
      end
      4'd2:    alu_out = alu_ain & alu_bin;
      4'd3:    alu_out = alu_ain | alu_bin;
      default: alu_out = '0;
    endcase
  end
  assign alu_status = {alu_out[31], m_ovf, (alu_out == 32'd0)};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction from requester r, with the response accepted at once.
  task automatic do_op(input int r, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ed, input logic [2:0] es,
                       input logic ee);
    logic [1:0] own;
    own = (r == 1) ? 2'b10 : 2'b01;
    if (r == 1) begin
      bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
    end else begin
      bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
    end
    bus.req_valid = own;
    #1;
    check("req_ready", {62'd0, bus.req_ready}, {62'd0, own});
    tick();
    bus.req_valid = 2'b00;
    if (!ee) begin
      check("exec_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
      check("exec_alu_op", {60'd0, alu_op}, {60'd0, op});
      check("exec_alu_ain", {32'd0, alu_ain}, {32'd0, a});
      tick();
    end
    check("rsp_valid", {62'd0, bus.rsp_valid}, {62'd0, own});
    check("rsp_data", {32'd0, bus.rsp_data}, {32'd0, ed});
    check("rsp_status", {61'd0, bus.rsp_status}, {61'd0, es});
    check("rsp_err", {63'd0, bus.rsp_err}, {63'd0, ee});
    bus.rsp_ready = own;
    tick();
    bus.rsp_ready = 2'b00;
    exp_count++;
    check("op_count", {48'd0, op_count}, {48'd0, exp_count});
    check("busy_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [1:0] own;
    checks        = 0;
    errors        = 0;
    exp_count     = '0;
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_op0   = '0; bus.req_a0 = '0; bus.req_b0 = '0;
    bus.req_op1   = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
    check("rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    check("rst_op_count", {48'd0, op_count}, 64'd0);
    check("rst_alu_op", {60'd0, alu_op}, 64'd0);
    check("rst_alu_ain", {32'd0, alu_ain}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single-requester ops covering all four ALU functions and status flags.
    do_op(0, 4'd0, 32'd5, 32'd7, 32'd12, 3'b000, 1'b0);
    do_op(0, 4'd2, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h00F0_00FF, 3'b000, 1'b0);
    do_op(0, 4'd3, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 3'b100, 1'b0);
    do_op(1, 4'd1, 32'd3, 32'd3, 32'd0, 3'b001, 1'b0);
    do_op(1, 4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 3'b110, 1'b0);

    // Both requesters valid: strict alternation starting with req 0.
    bus.req_op0 = 4'd0; bus.req_a0 = 32'd100;  bus.req_b0 = 32'd23;
    bus.req_op1 = 4'd3; bus.req_a1 = 32'h0F;   bus.req_b1 = 32'hF0;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      own = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check("rr_ready", {62'd0, bus.req_ready}, {62'd0, own});
      tick();
      tick();
      check("rr_rsp_valid", {62'd0, bus.rsp_valid}, {62'd0, own});
      check("rr_data", {32'd0, bus.rsp_data}, (i % 2 == 0) ? 64'd123 : 64'hFF);
      bus.rsp_ready = ~own;
      tick();
      check("rr_other_ready_ignored", {62'd0, bus.rsp_valid}, {62'd0, own});
      bus.rsp_ready = own;
      tick();
      bus.rsp_ready = 2'b00;
      exp_count++;
      check("rr_op_count", {48'd0, op_count}, {48'd0, exp_count});
    end
    bus.req_valid = 2'b00;

    // Illegal opcode: rejected without touching ALU inputs (last issued was OR 0x0F|0xF0).
    do_op(0, 4'h9, 32'd1, 32'd1, 32'd0, 3'b000, 1'b1);
    check("rej_alu_op_kept", {60'd0, alu_op}, 64'd3);
    check("rej_alu_ain_kept", {32'd0, alu_ain}, 64'h0F);

    // Response back-pressure: result held, no new grant while in RESP.
    bus.req_op1 = 4'd0; bus.req_a1 = 32'hFFFF_FFFF; bus.req_b1 = 32'd1;
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_rsp_valid", {62'd0, bus.rsp_valid}, 64'b10);
      check("hold_data", {32'd0, bus.rsp_data}, 64'd0);
      check("hold_status", {61'd0, bus.rsp_status}, 64'b001);
      check("hold_req_ready", {62'd0, bus.req_ready}, 64'd0);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;
    exp_count++;
    check("hold_op_count", {48'd0, op_count}, {48'd0, exp_count});
    check("hold_busy", {63'd0, busy}, 64'd0);

    // Reset during EXEC discards the transaction and clears everything.
    bus.req_op0 = 4'd0; bus.req_a0 = 32'd2; bus.req_b0 = 32'd2;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    check("exec_busy", {63'd0, busy}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    check("mid_rst_op_count", {48'd0, op_count}, 64'd0);
    check("mid_rst_alu_op", {60'd0, alu_op}, 64'd0);
    check("mid_rst_alu_ain", {32'd0, alu_ain}, 64'd0);
    check("mid_rst_rsp_data", {32'd0, bus.rsp_data}, 64'd0);
    check("mid_rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    bus.req_valid = 2'b11;
    #1;
    check("post_rst_first_grant", {62'd0, bus.req_ready}, 64'b01);
    bus.req_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
